// File: rtl/if_stage.sv
// rtl/if_stage.sv - LEGv8 instruction fetch stage with IF/ID pipeline register
// Optional perf counters (perf_fetched, perf_stall_cycles) under IF_PERF_CNT_EN.
module if_stage #(
    parameter int unsigned          PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    input  logic                stall,
    input  logic                flush,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic                if_id_valid,
    output logic [PC_WIDTH-1:0] if_id_pc,
    output logic [31:0]         if_id_instr,
    output logic [10:0]         if_id_opcode
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t              r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic                r_drop;
    logic [31:0]         r_skid_data;
    logic                r_if_id_valid;
    logic [PC_WIDTH-1:0] r_if_id_pc;
    logic [31:0]         r_if_id_instr;

    logic                w_can_accept;
    logic                w_load;
    logic [31:0]         w_load_data;
    logic [PC_WIDTH-1:0] w_pc_next;
    logic [PC_WIDTH-1:0] w_target;

    assign w_can_accept = !stall || !r_if_id_valid;
    assign w_pc_next    = r_pc + PC_WIDTH'(4);
    assign w_target     = branch_target & ~PC_WIDTH'(3);

    // HOLD means the skid buffer is full, so no separate occupancy flag is kept.
    assign w_load = !branch_taken && w_can_accept &&
                    (((r_state == S_WAIT) && imem_rvalid && !r_drop) ||
                     (r_state == S_HOLD));
    assign w_load_data = (r_state == S_HOLD) ? r_skid_data : imem_rdata;

    assign imem_req     = rst_n && (r_state == S_FETCH);
    assign imem_addr    = r_pc;
    assign if_id_valid  = r_if_id_valid;
    assign if_id_pc     = r_if_id_pc;
    assign if_id_instr  = r_if_id_instr;
    assign if_id_opcode = r_if_id_valid ? r_if_id_instr[31:21] : 11'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_drop        <= 1'b0;
            r_skid_data   <= 32'd0;
            r_if_id_valid <= 1'b0;
            r_if_id_pc    <= '0;
            r_if_id_instr <= 32'd0;
        end else if (branch_taken) begin
            r_pc          <= w_target;
            r_if_id_valid <= 1'b0;
            case (r_state)
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_state <= S_FETCH;
                        r_drop  <= 1'b0;
                    end else begin
                        r_drop  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    // A request accepted this cycle still returns data; it must be dropped.
                    if (imem_ready) begin
                        r_state <= S_WAIT;
                        r_drop  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                    r_drop  <= 1'b0;
                end
            endcase
        end else begin
            if (w_load) begin
                r_if_id_valid <= 1'b1;
                r_if_id_pc    <= r_pc;
                r_if_id_instr <= w_load_data;
                r_pc          <= w_pc_next;
            end else if (flush || w_can_accept) begin
                r_if_id_valid <= 1'b0;
            end

            case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= S_FETCH;
                        end else if (w_can_accept) begin
                            r_state <= S_FETCH;
                        end else begin
                            r_skid_data <= imem_rdata;
                            r_state     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_can_accept) begin
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall_cycles;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_fetched      <= 32'd0;
            r_perf_stall_cycles <= 32'd0;
        end else begin
            if (w_load) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (stall && r_if_id_valid) begin
                r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
            end
        end
    end

    assign perf_fetched      = r_perf_fetched;
    assign perf_stall_cycles = r_perf_stall_cycles;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage: directed scenarios then random traffic
module tb_if_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall, flush, branch_taken;
    logic [63:0] branch_target;
    logic        if_id_valid;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [10:0] if_id_opcode;

    logic        w1_req, w1_rvalid, w1_valid;
    logic [63:0] w1_addr, w1_pc;
    logic [31:0] w1_instr;
    logic [10:0] w1_opcode;
    logic        w1_acc;

`ifdef IF_PERF_CNT_EN
    logic [31:0] p0_fetched, p0_stall, p1_fetched, p1_stall;
`endif

    if_stage #(.PC_WIDTH(64), .RESET_PC(64'h0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .flush(flush), .branch_taken(branch_taken), .branch_target(branch_target),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
        .if_id_opcode(if_id_opcode)
`ifdef IF_PERF_CNT_EN
        , .perf_fetched(p0_fetched), .perf_stall_cycles(p0_stall)
`endif
    );

    if_stage #(.PC_WIDTH(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w1_req), .imem_addr(w1_addr), .imem_ready(1'b1),
        .imem_rvalid(w1_rvalid), .imem_rdata(32'hF84003E1),
        .stall(1'b0), .flush(1'b0), .branch_taken(1'b0), .branch_target(64'h0),
        .if_id_valid(w1_valid), .if_id_pc(w1_pc), .if_id_instr(w1_instr),
        .if_id_opcode(w1_opcode)
`ifdef IF_PERF_CNT_EN
        , .perf_fetched(p1_fetched), .perf_stall_cycles(p1_stall)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t q_exp[$];

    // Reference model: program-order PC plus the single outstanding memory transaction.
    logic [63:0] exp_pc;
    logic        mem_busy, mem_killed;
    int          mem_cnt, mem_lat;
    logic [63:0] mem_addr, mem_exp_pc;
    logic        fixed_word;
    logic [63:0] acc_log[$];
    logic [63:0] w1_log[$];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (fixed_word) return 32'hF84003E1;
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32];
    endfunction

    task automatic step(input logic st, input logic fl, input logic br,
                        input logic [63:0] tgt, input logic rdy);
        logic        deliver, accept, dkilled;
        logic [63:0] dpc;
        logic [31:0] dword;
        @(negedge clk);
        rst_n         = 1'b1;
        stall         = st;
        flush         = fl;
        branch_taken  = br;
        branch_target = tgt;
        imem_ready    = rdy;
        deliver       = mem_busy && (mem_cnt == 0);
        dkilled       = mem_killed;
        dpc           = mem_exp_pc;
        dword         = mem_word(mem_addr);
        imem_rvalid   = deliver;
        imem_rdata    = deliver ? dword : $urandom;
        #1;
        accept = imem_req && rdy;
        if (deliver) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (accept) begin
            check("fetch_addr", imem_addr, exp_pc);
            acc_log.push_back(imem_addr);
            mem_busy   = 1'b1;
            mem_cnt    = mem_lat;
            mem_addr   = imem_addr;
            mem_exp_pc = exp_pc;
            mem_killed = 1'b0;
        end
        if (br) begin
            q_exp.delete();
            mem_killed = 1'b1;
            exp_pc     = tgt & ~64'h3;
        end else if (deliver && !dkilled) begin
            q_exp.push_back('{dpc, dword});
            exp_pc = exp_pc + 64'd4;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every fresh IF/ID load must match the head of the scoreboard.
    logic        m_prev_valid = 1'b0;
    logic [63:0] m_prev_pc;
    logic [31:0] m_prev_instr;
    logic        m_held;
    exp_t        m_e;
    int          n_loads = 0;
    int          n_stallc = 0;
    int          w1_loads = 0;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            m_prev_valid = 1'b0;
        end else begin
            if (stall && m_prev_valid) n_stallc++;
            m_held = m_prev_valid && stall && !flush && !branch_taken;
            if (branch_taken) begin
                check("branch_clears_valid", {63'd0, if_id_valid}, 64'd0);
            end else if (m_held) begin
                check("hold_valid", {63'd0, if_id_valid}, 64'd1);
                check("hold_pc", if_id_pc, m_prev_pc);
                check("hold_instr", {32'd0, if_id_instr}, {32'd0, m_prev_instr});
            end else if (if_id_valid) begin
                n_loads++;
                if (q_exp.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_load: got pc %h expected no load", if_id_pc);
                end else begin
                    m_e = q_exp.pop_front();
                    check("load_pc", if_id_pc, m_e.pc);
                    check("load_instr", {32'd0, if_id_instr}, {32'd0, m_e.instr});
                    check("load_opcode", {53'd0, if_id_opcode}, {53'd0, m_e.instr[31:21]});
                end
            end
            if (!if_id_valid) check("bubble_opcode", {53'd0, if_id_opcode}, 64'd0);
            m_prev_valid = if_id_valid;
            m_prev_pc    = if_id_pc;
            m_prev_instr = if_id_instr;
            if (w1_valid) w1_loads++;
        end
    end

    // Always-ready memory for the wrap instance: data returns the cycle after acceptance.
    initial w1_acc = 1'b0;
    always @(negedge clk) begin
        #1;
        w1_rvalid = w1_acc;
        w1_acc    = w1_req;
        if (w1_acc) w1_log.push_back(w1_addr);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [63:0] pc_before;
    logic        st, fl, br;
    logic [63:0] tgt;

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
        branch_target = 64'h0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        w1_rvalid = 1'b0;
        exp_pc = 64'h0; mem_busy = 1'b0; mem_killed = 1'b0; mem_cnt = 0; mem_lat = 0;
        mem_addr = 64'h0; mem_exp_pc = 64'h0; fixed_word = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", {63'd0, imem_req}, 64'd0);
        check("rst_valid", {63'd0, if_id_valid}, 64'd0);
        check("rst_pc", if_id_pc, 64'd0);
        check("rst_instr", {32'd0, if_id_instr}, 64'd0);
        check("rst_opcode", {53'd0, if_id_opcode}, 64'd0);
        check("rst_req_wrap", {63'd0, w1_req}, 64'd0);
`ifdef IF_PERF_CNT_EN
        check("rst_perf_fetched", {32'd0, p0_fetched}, 64'd0);
        check("rst_perf_stall", {32'd0, p0_stall}, 64'd0);
`endif

        // Reset release: first instruction visible on the third cycle.
        step(0, 0, 0, 64'h0, 1);
        check("t1_valid_c1", {63'd0, if_id_valid}, 64'd0);
        step(0, 0, 0, 64'h0, 1);
        check("t1_valid_c2", {63'd0, if_id_valid}, 64'd1);
        check("t1_pc", if_id_pc, 64'd0);
        check("t1_opcode", {53'd0, if_id_opcode}, {53'd0, 11'b11111000010});
        step(0, 0, 0, 64'h0, 1);
        step(0, 0, 0, 64'h0, 1);
`ifdef IF_PERF_CNT_EN
        check("t6_perf_fetched_2", {32'd0, p1_fetched}, 64'd2);
`endif
        step(0, 0, 0, 64'h0, 1);
        step(0, 0, 0, 64'h0, 1);
        check("t1_addr0", acc_log[0], 64'h0);
        check("t1_addr1", acc_log[1], 64'h4);
        check("t1_addr2", acc_log[2], 64'h8);
        check("t6_wrap_addr0", w1_log[0], 64'hFFFF_FFFF_FFFF_FFFC);
        check("t6_wrap_addr1", w1_log[1], 64'h0);
        check("t6_wrap_instr", {32'd0, w1_instr}, {32'd0, 32'hF84003E1});
        check("t6_wrap_opcode", {53'd0, w1_opcode}, {53'd0, 11'b11111000010});

        // Stall while the next instruction returns into the skid buffer.
        check("t2_pre_valid", {63'd0, if_id_valid}, 64'd1);
        pc_before = if_id_pc;
        repeat (5) step(1, 0, 0, 64'h0, 1);
        check("t2_req_low", {63'd0, imem_req}, 64'd0);
        check("t2_held_pc", if_id_pc, pc_before);
        step(0, 0, 0, 64'h0, 1);
        check("t2_release_pc", if_id_pc, pc_before + 64'd4);
        check("t2_release_req", {63'd0, imem_req}, 64'd1);
        check("t2_release_addr", imem_addr, pc_before + 64'd8);

        // Redirect while waiting, before data returns.
        mem_lat = 2;
        step(0, 0, 0, 64'h0, 1);
        step(0, 0, 1, 64'h103, 1);
        check("t3_valid", {63'd0, if_id_valid}, 64'd0);
        step(0, 0, 0, 64'h0, 1);
        step(0, 0, 0, 64'h0, 1);
        check("t3_req", {63'd0, imem_req}, 64'd1);
        check("t3_addr", imem_addr, 64'h100);

        // Redirect in the same cycle as returning data.
        mem_lat = 0;
        step(0, 0, 0, 64'h0, 1);
        step(0, 0, 1, 64'h204, 1);
        check("t4_valid", {63'd0, if_id_valid}, 64'd0);
        check("t4_addr", imem_addr, 64'h204);

        // Flush while stalled with a full skid buffer.
        step(0, 0, 0, 64'h0, 1);
        step(0, 0, 0, 64'h0, 1);
        step(1, 0, 0, 64'h0, 1);
        step(1, 0, 0, 64'h0, 1);
        check("t5_pre_valid", {63'd0, if_id_valid}, 64'd1);
        step(1, 1, 0, 64'h0, 1);
        check("t5_valid", {63'd0, if_id_valid}, 64'd0);
        check("t5_opcode", {53'd0, if_id_opcode}, 64'd0);
        step(1, 0, 0, 64'h0, 1);
        check("t5_reload_valid", {63'd0, if_id_valid}, 64'd1);
        check("t5_reload_pc", if_id_pc, 64'h208);

        // Random traffic.
        fixed_word = 1'b0;
        repeat (3000) begin
            st  = ($urandom_range(0, 9) < 3);
            fl  = ($urandom_range(0, 19) == 0);
            br  = ($urandom_range(0, 19) == 0);
            tgt = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) tgt = 64'($urandom_range(0, 255));
            mem_lat = $urandom_range(0, 2);
            step(st, fl, br, tgt, ($urandom_range(0, 3) != 0));
        end
        @(negedge clk);
        check("liveness", {63'd0, (n_loads > 100)}, 64'd1);
`ifdef IF_PERF_CNT_EN
        check("perf_fetched", {32'd0, p0_fetched}, 64'(n_loads));
        check("perf_stall_cycles", {32'd0, p0_stall}, 64'(n_stallc));
        check("perf_fetched_wrap", {32'd0, p1_fetched}, 64'(w1_loads));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
LEGv8 instruction-fetch stage with IF/ID pipeline register. It owns the PC and issues one-outstanding-request fetches to instruction memory. It presents the fetched instruction, its PC and the decoded opcode field to the decode stage; the control-decode block consumes if_id_opcode directly. It handles back-pressure from decode (stall), redirect from the branch unit (branch_taken) and bubble insertion (flush).

Parameters:
PC_WIDTH, 64, width of PC, instruction address and branch target.
RESET_PC, 0, PC value loaded at reset.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  synchronous active-low reset.
imem_req  output  1  fetch request valid.
imem_addr  output  PC_WIDTH  fetch address; equals PC while imem_req=1.
imem_ready  input  1  memory accepts the request this cycle.
imem_rvalid  input  1  instruction data valid.
imem_rdata  input  32  fetched instruction word.
stall  input  1  decode cannot accept; hold IF/ID.
flush  input  1  clear IF/ID to bubble.
branch_taken  input  1  redirect fetch to branch_target.
branch_target  input  PC_WIDTH  redirect address; bits [1:0] are ignored and forced to 0.
if_id_valid  output  1  IF/ID holds a valid instruction.
if_id_pc  output  PC_WIDTH  PC of the IF/ID instruction.
if_id_instr  output  32  IF/ID instruction word.
if_id_opcode  output  11  if_id_instr[31:21]; forced to 0 when if_id_valid=0.

Behaviour:
- Reset (rst_n=0 at an edge): pc=RESET_PC, state=FETCH, drop=0, skid buffer empty, if_id_valid=0, if_id_pc=0, if_id_instr=0. imem_req=0 while rst_n=0.
- FETCH: imem_req=1, imem_addr=pc. When imem_ready=1, go to WAIT.
- WAIT: imem_req=0. On imem_rvalid:
  - drop=1: discard the data, clear drop, go to FETCH.
  - IF/ID can accept (stall=0 or if_id_valid=0): load IF/ID with valid=1, pc and rdata; pc<=pc+4; go to FETCH.
  - Otherwise: write rdata to the one-entry skid buffer; go to HOLD.
- HOLD: imem_req=0. When IF/ID can accept: move the buffer into IF/ID, pc<=pc+4, go to FETCH.
- Minimum latency: request accepted in cycle N, rvalid in N+1, IF/ID valid in N+2. Best-case throughput is one instruction every 2 cycles.
- branch_taken: highest priority, in any state.
  - pc<={branch_target[PC_WIDTH-1:2],2'b00}; if_id_valid<=0; skid buffer cleared.
  - From WAIT with no rvalid in the same cycle: set drop=1 and stay in WAIT.
  - From WAIT with rvalid in the same cycle: discard the data and go to FETCH.
  - From FETCH or HOLD: go to FETCH. A request accepted in the same cycle as the redirect is treated as in flight, so state goes to WAIT with drop=1.
- flush without branch_taken: if_id_valid<=0 only. An in-flight or buffered instruction is unaffected and loads normally later.
- flush and stall together: flush wins and IF/ID is cleared.
- stall with if_id_valid=1: all IF/ID outputs hold their values.
- PC arithmetic: modulo 2^PC_WIDTH; wraps from all-ones-minus-3 to 0 with no error.
- Memory contract: imem_rvalid is never asserted outside WAIT. imem_rvalid asserted in any other state is ignored.

Optional Feature:
IF_PERF_CNT_EN: when defined, adds two outputs.
- perf_fetched: 32-bit count of instructions loaded into IF/ID.
- perf_stall_cycles: 32-bit count of cycles with stall=1 and if_id_valid=1.
- Both reset to 0, wrap silently, and are never cleared by flush or branch_taken.
Without the macro these ports and their counters do not exist.

Test Plan:
1. Reset release with RESET_PC=0, memory always ready with 1-cycle rvalid, rdata=0xF84003E1 (LDUR) → imem_addr sequence 0,4,8; first if_id_valid=1 on the 3rd cycle after reset release with if_id_pc=0 and if_id_opcode=11'b11111000010.
2. Hold stall=1 for 5 cycles while an instruction returns → IF/ID unchanged; skid buffer fills; imem_req=0. Release stall → buffered instruction appears in IF/ID the next cycle, and PC advances by 4 exactly once.
3. Assert branch_taken with branch_target=0x103 in WAIT before rvalid → returned data discarded, if_id_valid=0, next imem_addr=0x100.
4. Assert branch_taken and imem_rvalid in the same cycle → the instruction never reaches IF/ID; next fetch address is the target.
5. Assert flush for 1 cycle while if_id_valid=1 and stall=1 → if_id_valid=0 and if_id_opcode=0; the following fetch loads normally.
6. Set RESET_PC=0xFFFF_FFFF_FFFF_FFFC → second fetch address is 0. With IF_PERF_CNT_EN defined, perf_fetched=2 after two loads.
